ext_mem_multichannel_model: RTL and testbench

//  Parametrised off-chip memory model serving the N_CH master ports of a Bambu-generated top (Mout_*/M_* bus).

---
 rtl/ext_mem_multichannel_model.sv | 180 ++++++++++++++++++
 tb/tb_ext_mem_multichannel_model.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_multichannel_model.sv
// rtl/ext_mem_multichannel_model.sv - multichannel off-chip memory model for Bambu master ports
//
// Byte-addressed memory window [BASE_ADDR, BASE_ADDR+MEMSIZE) shared by N_CH
// independent channels. Each channel has its own read/write latency sequencer.
// Writes are bit-masked by the access size. Slave-side Sout_* signals are ORed
// into the returned data and ready strobes.
//
// Ports:
//   clock, reset               rising-edge clock, async active-low reset
//   Mout_oe_ram/Mout_we_ram    per-channel read/write request
//   Mout_addr_ram              per-channel byte address
//   Mout_Wdata_ram             per-channel write data (little-endian bytes)
//   Mout_data_ram_size         per-channel access width in bits
//   Sout_Rdata_ram/Sout_DataRdy  slave-side data/ready, ORed into the outputs
//   init_we/init_addr/init_data  byte-wide backdoor preload (offset in window)
//   M_Rdata_ram/M_DataRdy      read data and access-complete strobe per channel
//   err_oe_we                  sticky flag: a channel requested oe and we together
module ext_mem_multichannel_model #(
  parameter int N_CH      = 2,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int MEMSIZE   = 32,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          Mout_oe_ram,
  input  logic [N_CH-1:0]          Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [N_CH*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [N_CH-1:0]          Sout_DataRdy,
  input  logic                     init_we,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic [7:0]               init_data,
  output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  output logic                     err_oe_we
);

  localparam int NB      = DATA_W / 8;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int MA_W    = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t             state   [N_CH];
  logic [CNT_W-1:0]   cnt     [N_CH];
  logic [DATA_W-1:0]  rd_q    [N_CH];
  logic [7:0]         mem     [MEMSIZE];
  logic               err_q;

  logic [31:0]        offs    [N_CH];
  logic [NB-1:0]      bok     [N_CH];
  logic [MA_W-1:0]    bidx    [N_CH][NB];
  logic [DATA_W-1:0]  rd_word [N_CH];
  logic [DATA_W-1:0]  wmask   [N_CH];
  logic [N_CH-1:0]    in_win;
  logic [N_CH-1:0]    req_rd;
  logic [N_CH-1:0]    req_wr;
  logic [N_CH-1:0]    rd_done;
  logic [N_CH-1:0]    wr_done;

  // Address decode, read word assembly, write mask and completion detection.
  // cnt holds the number of cycles already spent in RD/WR, so the current
  // cycle of the access is cnt+1 (the request cycle itself is cycle 1).
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      // Subtracting the base lets addresses below the window wrap to a large
      // value, so one unsigned compare covers both window bounds.
      offs[c]    = 32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]) - 32'(BASE_ADDR);
      in_win[c]  = offs[c] < 32'(MEMSIZE);
      bok[c]     = '0;
      rd_word[c] = '0;
      for (int b = 0; b < NB; b++) begin
        bok[c][b]  = (offs[c] + 32'(b)) < 32'(MEMSIZE);
        bidx[c][b] = MA_W'(offs[c] + 32'(b));
        rd_word[c][8*b +: 8] = bok[c][b] ? mem[bidx[c][b]] : 8'h00;
      end
      if (32'(Mout_data_ram_size[c*SIZE_W +: SIZE_W]) >= 32'(DATA_W))
        wmask[c] = '1;
      else
        wmask[c] = (DATA_W'(1) << Mout_data_ram_size[c*SIZE_W +: SIZE_W]) - DATA_W'(1);
      req_rd[c] = Mout_oe_ram[c] & ~Mout_we_ram[c] & in_win[c];
      req_wr[c] = Mout_we_ram[c] & ~Mout_oe_ram[c] & in_win[c];
      // Reset held low masks completion so an aborted access has no effect.
      rd_done[c] = reset & req_rd[c] &
                   (((state[c] == S_IDLE) && (RD_LAT == 1)) ||
                    ((state[c] == S_RD) && (32'(cnt[c]) + 32'd1 == 32'(RD_LAT))));
      wr_done[c] = reset & req_wr[c] &
                   (((state[c] == S_IDLE) && (WR_LAT == 1)) ||
                    ((state[c] == S_WR) && (32'(cnt[c]) + 32'd1 == 32'(WR_LAT))));
    end
  end

  // Output merge: model contributes data only in the ready cycle of a read.
  always_comb begin
    M_Rdata_ram = Sout_Rdata_ram;
    M_DataRdy   = Sout_DataRdy | rd_done | wr_done;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_done[c])
        M_Rdata_ram[c*DATA_W +: DATA_W] = Sout_Rdata_ram[c*DATA_W +: DATA_W] |
                                          ((RD_LAT == 1) ? rd_word[c] : rd_q[c]);
    end
  end

  assign err_oe_we = err_q;

  // Per-channel latency sequencers. Read data is captured at acceptance and
  // held, which matches an RD_LAT-1 deep pipe as the request stays stable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        state[c] <= S_IDLE;
        cnt[c]   <= '0;
        rd_q[c]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (|(Mout_oe_ram & Mout_we_ram))
        err_q <= 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        case (state[c])
          S_IDLE: begin
            if (req_rd[c] && !rd_done[c]) begin
              state[c] <= S_RD;
              cnt[c]   <= CNT_W'(1);
              rd_q[c]  <= rd_word[c];
            end else if (req_wr[c] && !wr_done[c]) begin
              state[c] <= S_WR;
              cnt[c]   <= CNT_W'(1);
            end
          end
          S_RD: begin
            if (!req_rd[c] || rd_done[c]) begin
              state[c] <= S_IDLE;
              cnt[c]   <= '0;
            end else begin
              cnt[c] <= cnt[c] + CNT_W'(1);
            end
          end
          S_WR: begin
            if (!req_wr[c] || wr_done[c]) begin
              state[c] <= S_IDLE;
              cnt[c]   <= '0;
            end else begin
              cnt[c] <= cnt[c] + CNT_W'(1);
            end
          end
          default: begin
            state[c] <= S_IDLE;
            cnt[c]   <= '0;
          end
        endcase
      end
    end
  end

  // Memory array, never cleared. Later assignments win: backdoor first, then
  // channels in ascending index so the highest channel owns a contested byte.
  always_ff @(posedge clock) begin
    if (init_we && (32'(init_addr) < 32'(MEMSIZE)))
      mem[MA_W'(init_addr)] <= init_data;
    for (int c = 0; c < N_CH; c++) begin
      if (wr_done[c]) begin
        for (int b = 0; b < NB; b++) begin
          if (bok[c][b])
            mem[bidx[c][b]] <= (Mout_Wdata_ram[c*DATA_W + 8*b +: 8] & wmask[c][8*b +: 8]) |
                               (mem[bidx[c][b]] & ~wmask[c][8*b +: 8]);
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_mem_multichannel_model.sv
// tb/tb_ext_mem_multichannel_model.sv - self-checking bench for ext_mem_multichannel_model
module tb_ext_mem_multichannel_model;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [1:0]  oe, we, srdy;
  logic [13:0] addr;
  logic [15:0] wdata, sdata;
  logic [7:0]  size;
  logic        iwe;
  logic [6:0]  iaddr;
  logic [7:0]  idata;
  logic [15:0] rdata, rdata4;
  logic [1:0]  rdy, rdy4;
  logic        err, err4;

  int n_cmp = 0;
  int n_bad = 0;

  ext_mem_multichannel_model dut (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .Sout_Rdata_ram(sdata), .Sout_DataRdy(srdy),
    .init_we(iwe), .init_addr(iaddr), .init_data(idata),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy), .err_oe_we(err)
  );

  ext_mem_multichannel_model #(.RD_LAT(4)) dut4 (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .Sout_Rdata_ram(sdata), .Sout_DataRdy(srdy),
    .init_we(iwe), .init_addr(iaddr), .init_data(idata),
    .M_Rdata_ram(rdata4), .M_DataRdy(rdy4), .err_oe_we(err4)
  );

  typedef struct {
    string       nm;
    logic [1:0]  oe, we, srdy;
    logic [6:0]  a0, a1;
    logic [7:0]  w0, w1;
    logic [3:0]  s0, s1;
    logic [7:0]  so0;
    logic        iwe;
    logic [6:0]  iaddr;
    logic [7:0]  idata;
    logic [1:0]  e_rdy;
    logic [7:0]  e_d0, e_d1;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t idle(string nm);
    vec_t v;
    v.nm = nm; v.oe = '0; v.we = '0; v.srdy = '0; v.a0 = '0; v.a1 = '0;
    v.w0 = '0; v.w1 = '0; v.s0 = '0; v.s1 = '0; v.so0 = '0;
    v.iwe = 1'b0; v.iaddr = '0; v.idata = '0;
    v.e_rdy = '0; v.e_d0 = '0; v.e_d1 = '0;
    return v;
  endfunction

  function automatic vec_t ini(string nm, logic [6:0] a, logic [7:0] d);
    vec_t v = idle(nm);
    v.iwe = 1'b1; v.iaddr = a; v.idata = d;
    return v;
  endfunction

  function automatic vec_t rd(string nm, int ch, logic [6:0] a, logic e, logic [7:0] d);
    vec_t v = idle(nm);
    v.oe[ch] = 1'b1;
    v.e_rdy[ch] = e;
    if (ch == 0) begin v.a0 = a; v.e_d0 = e ? d : 8'h00; end
    else         begin v.a1 = a; v.e_d1 = e ? d : 8'h00; end
    return v;
  endfunction

  // WR_LAT=1: every in-window write completes in its request cycle.
  function automatic vec_t wr(string nm, int ch, logic [6:0] a, logic [7:0] w, logic [3:0] s);
    vec_t v = idle(nm);
    v.we[ch] = 1'b1;
    v.e_rdy[ch] = 1'b1;
    if (ch == 0) begin v.a0 = a; v.w0 = w; v.s0 = s; end
    else         begin v.a1 = a; v.w1 = w; v.s1 = s; end
    return v;
  endfunction

  task automatic drive(vec_t v);
    oe = v.oe; we = v.we; srdy = v.srdy;
    addr = {v.a1, v.a0}; wdata = {v.w1, v.w0}; size = {v.s1, v.s0};
    sdata = {8'h00, v.so0};
    iwe = v.iwe; iaddr = v.iaddr; idata = v.idata;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;

    // Preload and boundary bytes.
    tbl.push_back(ini("init5", 7'd5, 8'hA7));
    tbl.push_back(ini("init3", 7'd3, 8'hFF));
    tbl.push_back(ini("init7", 7'd7, 8'h00));
    tbl.push_back(ini("init31", 7'd31, 8'h5E));
    tbl.push_back(ini("init9", 7'd9, 8'h00));
    tbl.push_back(ini("init40_ign", 7'd40, 8'h99));
    // T1: RD_LAT=2, held read completes every second cycle.
    tbl.push_back(rd("t1_c1", 0, 7'd5, 1'b0, 8'h00));
    tbl.push_back(rd("t1_c2", 0, 7'd5, 1'b1, 8'hA7));
    tbl.push_back(rd("t1_c3", 0, 7'd5, 1'b0, 8'h00));
    tbl.push_back(rd("t1_c4", 0, 7'd5, 1'b1, 8'hA7));
    tbl.push_back(idle("t1_idle"));
    // T2: size-4 mask, then size 0 leaves the byte alone.
    tbl.push_back(wr("t2_wr", 1, 7'd3, 8'h12, 4'd4));
    tbl.push_back(rd("t2_rd1", 1, 7'd3, 1'b0, 8'h00));
    tbl.push_back(rd("t2_rd2", 1, 7'd3, 1'b1, 8'hF2));
    tbl.push_back(wr("t2_wr0", 1, 7'd3, 8'h00, 4'd0));
    tbl.push_back(rd("t2_rd3", 1, 7'd3, 1'b0, 8'h00));
    tbl.push_back(rd("t2_rd4", 1, 7'd3, 1'b1, 8'hF2));
    // T3: both channels write byte 7 on one edge.
    v = idle("t3_wr"); v.we = 2'b11; v.a0 = 7'd7; v.a1 = 7'd7;
    v.w0 = 8'h11; v.w1 = 8'h22; v.s0 = 4'd8; v.s1 = 4'd8; v.e_rdy = 2'b11;
    tbl.push_back(v);
    v = idle("t3_rd1"); v.oe = 2'b11; v.a0 = 7'd7; v.a1 = 7'd5;
    tbl.push_back(v);
    v.nm = "t3_rd2"; v.e_rdy = 2'b11; v.e_d0 = 8'h22; v.e_d1 = 8'hA7;
    tbl.push_back(v);
    // T4: out-of-window read, only the slave side answers.
    v = idle("t4_a"); v.oe = 2'b01; v.a0 = 7'd32; v.so0 = 8'h3C; v.srdy = 2'b01;
    v.e_rdy = 2'b01; v.e_d0 = 8'h3C;
    tbl.push_back(v);
    v.nm = "t4_b"; tbl.push_back(v);
    v.nm = "t4_c"; v.srdy = 2'b00; v.e_rdy = 2'b00; tbl.push_back(v);
    v.nm = "t4_d"; tbl.push_back(v);
    // Last byte of the window.
    tbl.push_back(rd("last1", 0, 7'd31, 1'b0, 8'h00));
    tbl.push_back(rd("last2", 0, 7'd31, 1'b1, 8'h5E));
    // Read accepted on the same edge as a write to that byte sees old data.
    v = idle("raw_a"); v.oe = 2'b01; v.we = 2'b10; v.a0 = 7'd3; v.a1 = 7'd3;
    v.w1 = 8'h3C; v.s1 = 4'd8; v.e_rdy = 2'b10;
    tbl.push_back(v);
    tbl.push_back(rd("raw_b", 0, 7'd3, 1'b1, 8'hF2));
    tbl.push_back(idle("raw_idle"));
    tbl.push_back(rd("raw_c", 0, 7'd3, 1'b0, 8'h00));
    tbl.push_back(rd("raw_d", 0, 7'd3, 1'b1, 8'h3C));
    // Channel write beats backdoor on the same byte.
    v = wr("prio_wr", 0, 7'd9, 8'h44, 4'd8); v.iwe = 1'b1; v.iaddr = 7'd9; v.idata = 8'h55;
    tbl.push_back(v);
    tbl.push_back(rd("prio_rd1", 0, 7'd9, 1'b0, 8'h00));
    tbl.push_back(rd("prio_rd2", 0, 7'd9, 1'b1, 8'h44));
    // Oversized size gives full width; size 1 touches only bit 0.
    tbl.push_back(wr("sz15_wr", 0, 7'd9, 8'hC3, 4'd15));
    tbl.push_back(rd("sz15_rd1", 0, 7'd9, 1'b0, 8'h00));
    tbl.push_back(rd("sz15_rd2", 0, 7'd9, 1'b1, 8'hC3));
    tbl.push_back(wr("sz1_wr", 0, 7'd9, 8'h00, 4'd1));
    tbl.push_back(rd("sz1_rd1", 0, 7'd9, 1'b0, 8'h00));
    tbl.push_back(rd("sz1_rd2", 0, 7'd9, 1'b1, 8'hC2));
    // Request dropped mid-read: no ready, restart takes full latency.
    tbl.push_back(rd("drop_a", 0, 7'd5, 1'b0, 8'h00));
    tbl.push_back(idle("drop_b"));
    tbl.push_back(rd("drop_c", 0, 7'd5, 1'b0, 8'h00));
    tbl.push_back(rd("drop_d", 0, 7'd5, 1'b1, 8'hA7));
    tbl.push_back(idle("drop_idle"));

    // Reset state: outputs follow the slave side only.
    reset = 1'b0;
    drive(idle("rst"));
    oe = 2'b01; srdy = 2'b10; sdata = 16'h005A;
    @(negedge clock);
    chk("rst_rdy", 32'(rdy), 32'h2);
    chk("rst_data", 32'(rdata), 32'h005A);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdy4", 32'(rdy4), 32'h2);
    next_cycle();
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clock);
      chk($sformatf("%s_rdy", tbl[i].nm), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("%s_d0", tbl[i].nm), 32'(rdata[7:0]), 32'(tbl[i].e_d0));
      chk($sformatf("%s_d1", tbl[i].nm), 32'(rdata[15:8]), 32'(tbl[i].e_d1));
      chk($sformatf("%s_err", tbl[i].nm), 32'(err), 32'h0);
      next_cycle();
    end

    // T5: oe and we together, one cycle.
    v = idle("t5"); v.oe = 2'b01; v.we = 2'b01; v.a0 = 7'd5; v.w0 = 8'h00; v.s0 = 4'd8;
    drive(v);
    @(negedge clock);
    chk("t5_rdy", 32'(rdy), 32'h0);
    chk("t5_err_same", 32'(err), 32'h0);
    next_cycle();
    drive(idle("t5_idle"));
    @(negedge clock);
    chk("t5_err_set", 32'(err), 32'h1);
    next_cycle();
    drive(rd("t5_rd", 0, 7'd5, 1'b0, 8'h00));
    next_cycle();
    @(negedge clock);
    chk("t5_rd_rdy", 32'(rdy), 32'h1);
    chk("t5_rd_data", 32'(rdata[7:0]), 32'hA7);
    chk("t5_err_hold", 32'(err), 32'h1);
    next_cycle();
    drive(idle("t6_pre"));
    repeat (5) next_cycle();

    // T6: RD_LAT=4 read aborted by reset in cycle 2, then re-issued.
    drive(rd("t6", 0, 7'd5, 1'b0, 8'h00));
    @(negedge clock);
    chk("t6_c1_rdy4", 32'(rdy4), 32'h0);
    next_cycle();
    reset = 1'b0;
    srdy = 2'b10; sdata = 16'h6600;
    @(negedge clock);
    chk("t6_rst_rdy4", 32'(rdy4), 32'h2);
    chk("t6_rst_data4", 32'(rdata4), 32'h6600);
    next_cycle();
    srdy = 2'b00; sdata = 16'h0000;
    @(negedge clock);
    chk("t6_rst2_rdy4", 32'(rdy4), 32'h0);
    next_cycle();
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("t6_re_c%0d_rdy4", k), 32'(rdy4), 32'h0);
      next_cycle();
    end
    @(negedge clock);
    chk("t6_re_c4_rdy4", 32'(rdy4), 32'h1);
    chk("t6_re_c4_data4", 32'(rdata4[7:0]), 32'hA7);
    chk("t6_err_clr", 32'(err), 32'h0);
    chk("t6_err4_clr", 32'(err4), 32'h0);
    next_cycle();
    drive(idle("end"));
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
